// File: rtl/mem_burst_ctrl_pkg.sv
// Shared types and constants for the burst request sequencer and its
// 16x8 register-file memory.
package mem_pkg;

   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR       = 3'd1,
      RD_ISSUE = 3'd2,
      RD_CAP   = 3'd3,
      RD_HOLD  = 3'd4
   } state_t;

   // Register-select increment; the natural overflow of ADDR_W bits gives the wrap.
   function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
      return a + {{(ADDR_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Command, write-byte and read-byte streams between a requester (master)
// and the burst controller (slave).
interface mem_burst_ctrl_if;
   import mem_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] req_len;

   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;

   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;

   modport master (
      output req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
      input  req_ready, wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_len, wr_valid, wr_data, rd_ready,
      output req_ready, wr_ready, rd_valid, rd_data
   );

endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst sequencer for the 16x8 register file: accepts one read or write
// burst at a time, walks the register select with wrap, and streams bytes.
// Reads take three cycles per byte (issue, capture, hand-off); writes one.
module mem_burst_ctrl
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   mem_burst_ctrl_if.slave   bus,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W-1:0] mem_sel,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              done_q, done_d;

   logic              req_ready_c;
   logic              wr_ready_c;
   logic              rd_valid_c;

   // State, address, count, read byte and done pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= {ADDR_W{1'b0}};
         cnt_q     <= {ADDR_W{1'b0}};
         rd_data_q <= {DATA_W{1'b0}};
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic: command accept, per-byte address/count update, done.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      rd_data_d = rd_data_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               cnt_d   = bus.req_len;
               state_d = bus.req_write ? WR : RD_ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         WR: begin
            if (bus.wr_valid) begin
               addr_d = addr_inc(addr_q);
               if (cnt_q == {ADDR_W{1'b0}}) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end else begin
               state_d = WR;
            end
         end
         RD_ISSUE: begin
            state_d = RD_CAP;
         end
         RD_CAP: begin
            rd_data_d = mem_rdata;
            state_d   = RD_HOLD;
         end
         RD_HOLD: begin
            if (bus.rd_ready) begin
               addr_d = addr_inc(addr_q);
               if (cnt_q == {ADDR_W{1'b0}}) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d   = cnt_q - {{(ADDR_W-1){1'b0}}, 1'b1};
                  state_d = RD_ISSUE;
               end
            end else begin
               state_d = RD_HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode; mem_we follows wr_valid only while in WR, so an
   // asynchronous reset forces it low at once.
   always_comb begin
      req_ready_c = 1'b0;
      wr_ready_c  = 1'b0;
      rd_valid_c  = 1'b0;
      mem_we      = 1'b0;
      mem_wdata   = {DATA_W{1'b0}};
      busy        = 1'b1;
      case (state_q)
         IDLE: begin
            req_ready_c = 1'b1;
            busy        = 1'b0;
         end
         WR: begin
            wr_ready_c = 1'b1;
            mem_we     = bus.wr_valid;
            mem_wdata  = bus.wr_data;
         end
         RD_ISSUE, RD_CAP: begin
            busy = 1'b1;
         end
         RD_HOLD: begin
            rd_valid_c = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Register select is the burst address register: stable in IDLE and
   // throughout a held read byte.
   assign mem_sel       = addr_q;
   assign done          = done_q;
   assign bus.req_ready = req_ready_c;
   assign bus.wr_ready  = wr_ready_c;
   assign bus.rd_valid  = rd_valid_c;
   assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl with a behavioural 16x8 register file.
module tb_mem_burst_ctrl;
   import mem_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic [3:0] mem_sel;
   logic [7:0] mem_rdata;
   logic       busy;
   logic       done;

   mem_burst_ctrl_if bus_if();

   mem_burst_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_if),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_sel   (mem_sel),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Register file: synchronous write, read data registered one clock after select.
   logic [7:0] mem_arr [16];
   always @(posedge clk) begin
      if (mem_we) mem_arr[mem_sel] <= mem_wdata;
      mem_rdata <= mem_arr[mem_sel];
   end

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;
   int exp_done = 0;
   logic [11:0] exp_wr [$];
   logic [7:0]  exp_rd [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Monitor: pops expected writes/reads whenever the DUT presents them, counts done.
   always @(negedge clk) begin
      logic [11:0] ew;
      logic [7:0]  er;
      if (rst_n === 1'b1) begin
         if (mem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: sel %0d data 0x%0h, required no write", mem_sel, mem_wdata);
            end else begin
               ew = exp_wr.pop_front();
               chk("write_sel_data", {20'd0, mem_sel, mem_wdata}, {20'd0, ew});
            end
         end
         if (bus_if.rd_valid === 1'b1 && bus_if.rd_ready === 1'b1) begin
            if (exp_rd.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read: data 0x%0h, required no read byte", bus_if.rd_data);
            end else begin
               er = exp_rd.pop_front();
               chk("read_data", {24'd0, bus_if.rd_data}, {24'd0, er});
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            chk("done_idle_ready", {30'd0, busy, bus_if.req_ready}, 32'd1);
         end
      end
   end

   task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] l);
      logic acc = 1'b0;
      bus_if.req_valid = 1'b1;
      bus_if.req_write = w;
      bus_if.req_addr  = a;
      bus_if.req_len   = l;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk) acc = bus_if.req_ready;
         @(posedge clk) #1;
         if (acc) break;
      end
      bus_if.req_valid = 1'b0;
      if (!acc) timeout_fail("req_accept");
   endtask

   task automatic wr_byte(input logic [3:0] sel, input logic [7:0] d);
      logic r = 1'b0;
      exp_wr.push_back({sel, d});
      bus_if.wr_valid = 1'b1;
      bus_if.wr_data  = d;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk) r = bus_if.wr_ready;
         @(posedge clk) #1;
         if (r) break;
      end
      bus_if.wr_valid = 1'b0;
      if (!r) timeout_fail("wr_accept");
   endtask

   // Consume n read bytes; byte stall_idx is held off with rd_ready low.
   task automatic read_bytes(input int n, input int stall_idx, input logic [3:0] start);
      logic ok;
      for (int i = 0; i < n; i++) begin
         ok = 1'b0;
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_if.rd_valid) begin ok = 1'b1; break; end
         end
         if (!ok) timeout_fail("rd_valid_wait");
         if (i == stall_idx) begin
            repeat (5) begin
               @(negedge clk);
               chk("bp_valid", {31'd0, bus_if.rd_valid}, 32'd1);
               chk("bp_data",  {24'd0, bus_if.rd_data}, {24'd0, exp_rd[0]});
               chk("bp_sel",   {28'd0, mem_sel}, {28'd0, 4'(start + 4'(i))});
            end
         end
         @(posedge clk) #1 bus_if.rd_ready = 1'b1;
         @(posedge clk) #1 bus_if.rd_ready = 1'b0;
      end
   endtask

   task automatic wait_done(input string name);
      logic seen = 1'b0;
      if (done === 1'b1) seen = 1'b1;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) timeout_fail(name);
      @(posedge clk) #1;
      chk(name, done_cnt, exp_done);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic acc;
      bus_if.req_valid = 1'b0; bus_if.req_write = 1'b0;
      bus_if.req_addr  = 4'd0; bus_if.req_len   = 4'd0;
      bus_if.wr_valid  = 1'b0; bus_if.wr_data   = 8'd0;
      bus_if.rd_ready  = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      // Reset state
      chk("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd1);
      chk("rst_wr_ready",  {31'd0, bus_if.wr_ready},  32'd0);
      chk("rst_rd_valid",  {31'd0, bus_if.rd_valid},  32'd0);
      chk("rst_rd_data",   {24'd0, bus_if.rd_data},   32'd0);
      chk("rst_mem_bus",   {19'd0, mem_we, mem_wdata, mem_sel}, 32'd0);
      chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk) #1;

      // Reset mid-write burst: two bytes land, the third is cut off asynchronously
      issue(1'b1, 4'd0, 4'd7);
      wr_byte(4'd0, 8'hC1);
      wr_byte(4'd1, 8'hC2);
      bus_if.wr_valid = 1'b1;
      bus_if.wr_data  = 8'hEE;
      #2;
      chk("we_before_reset", {31'd0, mem_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("we_async_drop", {31'd0, mem_we}, 32'd0);
      chk("abort_ready_busy", {30'd0, bus_if.req_ready, busy}, 32'd2);
      @(posedge clk);
      #3 bus_if.wr_valid = 1'b0;
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("post_abort_idle", {30'd0, bus_if.req_ready, busy}, 32'd2);
      end
      chk("abort_no_done", done_cnt, 32'd0);
      chk("abort_wr_queue", exp_wr.size(), 32'd0);
      @(posedge clk) #1;

      // Write burst 2..5, back-to-back
      issue(1'b1, 4'd2, 4'd3);
      wr_byte(4'd2, 8'hA1);
      wr_byte(4'd3, 8'hA2);
      wr_byte(4'd4, 8'hA3);
      wr_byte(4'd5, 8'hA4);
      exp_done++;
      wait_done("done_write");
      chk("write_queue_empty", exp_wr.size(), 32'd0);

      // Write burst 8..11 with a stall cycle between bytes
      issue(1'b1, 4'd8, 4'd3);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            bus_if.wr_valid = 1'b0;
            @(negedge clk);
            chk("stall_no_we", {31'd0, mem_we}, 32'd0);
            chk("stall_sel", {28'd0, mem_sel}, 32'(8 + i));
            @(posedge clk) #1;
         end
         wr_byte(4'(8 + i), 8'(8'hB1 + i));
      end
      exp_done++;
      wait_done("done_stall_write");
      chk("stall_queue_empty", exp_wr.size(), 32'd0);

      // 16-byte write from 6 (reg[k]=0x10+k) with a read request held throughout
      issue(1'b1, 4'd6, 4'd15);
      bus_if.req_valid = 1'b1;
      bus_if.req_write = 1'b0;
      bus_if.req_addr  = 4'd6;
      bus_if.req_len   = 4'd15;
      fork
         begin
            for (int i = 0; i < 16; i++) wr_byte(4'(6 + i), 8'(8'h10 + ((6 + i) % 16)));
         end
         begin
            acc = 1'b0;
            for (int k = 0; k < 200; k++) begin
               @(negedge clk);
               if (bus_if.req_ready) begin
                  chk("accept_in_done_cycle", {31'd0, done}, 32'd1);
                  acc = 1'b1;
                  @(posedge clk) #1 bus_if.req_valid = 1'b0;
                  break;
               end
            end
            if (!acc) timeout_fail("held_req_accept");
         end
      join
      exp_done++;
      for (int i = 0; i < 16; i++) exp_rd.push_back(8'(8'h10 + ((6 + i) % 16)));
      read_bytes(16, -1, 4'd6);
      exp_done++;
      wait_done("done_full_read");
      chk("full_wrap_sel", {28'd0, mem_sel}, 32'd6);
      chk("full_queue_empty", exp_rd.size() + exp_wr.size(), 32'd0);

      // Read wrap: 14, 15, 0, 1
      exp_rd.push_back(8'h1E); exp_rd.push_back(8'h1F);
      exp_rd.push_back(8'h10); exp_rd.push_back(8'h11);
      issue(1'b0, 4'd14, 4'd3);
      read_bytes(4, -1, 4'd14);
      exp_done++;
      wait_done("done_read_wrap");
      chk("wrap_queue_empty", exp_rd.size(), 32'd0);

      // Read with backpressure on the second byte
      exp_rd.push_back(8'h10); exp_rd.push_back(8'h11); exp_rd.push_back(8'h12);
      issue(1'b0, 4'd0, 4'd2);
      read_bytes(3, 1, 4'd0);
      exp_done++;
      wait_done("done_read_bp");
      chk("bp_queue_empty", exp_rd.size(), 32'd0);

      repeat (3) @(posedge clk);
      chk("final_done_count", done_cnt, exp_done);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
